hh_spike_detector: RTL and testbench
====================================

Name: hh_spike_detector

Overview:
Downstream stage of the HH neuron core. Consumes the neuron's 14-bit membrane voltage each clock and detects action potentials using a hysteresis threshold plus a refractory window. Emits a one-cycle spike pulse, a spike count, the inter-spike interval (ISI) in clock cycles and the peak voltage of the last spike. These feed the top-level output mux and any downstream spike-rate logic.

Parameters:
THRESH_HI, 14'sd2048, signed rising-crossing threshold (raw voltage code)
THRESH_LO, 14'sd1536, signed falling/re-arm threshold; must satisfy THRESH_LO <= THRESH_HI
REFRACT_CYCLES, 16, cycles spent in REFRACT after a spike ends; 0 is legal
ISI_W, 16, width of the ISI counter and output
CNT_W, 8, width of the spike counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
v_in  in  14  signed membrane voltage from the neuron core (V_new), new value every cycle
clr  in  1  synchronous clear of spike_count and isi_valid
spike  out  1  one-cycle pulse per detected spike
spike_count  out  CNT_W  spikes since reset/clr, wraps modulo 2^CNT_W
isi  out  ISI_W  cycles between the last two spike pulses, saturating
isi_valid  out  1  high once two spikes have been seen since reset/clr
peak_v  out  14  signed maximum v_reg during the most recent completed spike
state  out  2  FSM state: 0 ARM, 1 BELOW, 2 ABOVE, 3 REFRACT

Behaviour:
- Interface: one clock domain (clk). rst_n is synchronous and active-low; all flops update only on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - state=ARM; spike=0, spike_count=0, isi=0, isi_valid=0, peak_v=0.
  - Internal v_reg=0, refractory counter=0, isi_cnt=0.
  - A reset asserted mid-spike or mid-refractory aborts it immediately.
- Input stage: v_reg <= v_in every cycle. All comparisons are signed and use v_reg, never v_in.
- ARM: stays until v_reg < THRESH_LO, then moves to BELOW. This prevents a false spike when reset releases while the membrane is already depolarised.
- BELOW -> ABOVE when v_reg >= THRESH_HI:
  - spike is registered high for exactly the next cycle.
  - Latency: v_in crossing presented at edge k, spike high after edge k+2.
  - The peak tracker loads v_reg.
- ABOVE:
  - peak tracker <= max(peak tracker, v_reg).
  - When v_reg < THRESH_LO: peak_v <= peak tracker, refractory counter loads REFRACT_CYCLES.
  - Next state is REFRACT, or BELOW directly if REFRACT_CYCLES=0.
  - No further spike can fire while in ABOVE, regardless of v_reg.
- REFRACT:
  - Counter decrements each cycle; at 1, next state is BELOW. Dwell is exactly REFRACT_CYCLES cycles.
  - Threshold crossings are ignored.
  - If v_reg >= THRESH_HI on the first BELOW cycle, a spike fires normally.
- ISI counter:
  - On a spike event, isi_cnt <= 1; otherwise it increments, saturating at 2^ISI_W-1.
  - On a spike event with at least one prior spike: isi <= isi_cnt (saturated value if saturated) and isi_valid <= 1.
  - Result: isi equals the cycle distance between consecutive spike pulses.
- spike_count increments on each spike event and wraps from 2^CNT_W-1 to 0.
- clr:
  - Sets spike_count=0, isi_valid=0 and forgets the prior spike. isi and peak_v hold their values.
  - FSM and isi_cnt are unaffected.
  - clr coinciding with a spike event: spike_count=1, the event counts as the first spike, isi_valid stays 0.
- spike asserted while rst_n=0 at the next edge is cleared to 0.

Test Plan:
- Reset release with v_in=3000 held: state stays ARM and spike never fires. Then drive v_in=1000: BELOW after 2 edges, no spike.
- Single spike: v_in sequence 1000, 2048, 2500, 3100, 2000, 1535, 1000 (one per cycle).
  - spike high exactly once, 2 edges after 2048 is presented.
  - peak_v=3100; state passes ABOVE -> REFRACT for 16 cycles -> BELOW; spike_count=1, isi_valid=0.
- Hysteresis: after ABOVE, oscillate v_in between 1600 and 2100 for 20 cycles -> no second spike, state remains ABOVE.
- Two spikes, crossing edges 100 cycles apart -> isi=100, isi_valid=1, spike_count=2. A stimulus crossing during REFRACT produces no spike and does not change isi.
- Saturation/wrap with ISI_W=4, CNT_W=2: spikes 40 cycles apart -> isi=15. Five spikes -> spike_count=1.
- Boundary events:
  - clr on a spike-event cycle -> spike_count=1, isi_valid=0.
  - rst_n low during REFRACT -> state=ARM and all outputs zero next cycle.
  - REFRACT_CYCLES=0 -> ABOVE goes directly to BELOW.

Source files
------------

// File: rtl/hh_spike_detector.sv
`default_nettype none
// ============================================================================
// Module      : hh_spike_detector
// Description : Action-potential detector for the HH neuron core. Registers
//               the membrane voltage, applies hysteresis thresholds and a
//               refractory window, and reports spike pulse, spike count,
//               inter-spike interval and peak voltage of the last spike.
// Revision    : 1.0 - initial release
// ============================================================================
module hh_spike_detector #(
  parameter logic signed [13:0] THRESH_HI      = 14'sd2048,
  parameter logic signed [13:0] THRESH_LO      = 14'sd1536,
  parameter int unsigned        REFRACT_CYCLES = 16,
  parameter int unsigned        ISI_W          = 16,
  parameter int unsigned        CNT_W          = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [13:0]      v_in,
  input  logic                    clr,
  output logic                    spike,
  output logic [CNT_W-1:0]        spike_count,
  output logic [ISI_W-1:0]        isi,
  output logic                    isi_valid,
  output logic signed [13:0]      peak_v,
  output logic [1:0]              state
);

  localparam int RC_W = (REFRACT_CYCLES < 2) ? 1 : $clog2(REFRACT_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRACT_CYCLES);

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_BELOW   = 2'd1,
    ST_ABOVE   = 2'd2,
    ST_REFRACT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic signed [13:0]     v_reg_q, v_reg_d;
  logic                   v_valid_q, v_valid_d;
  logic                   spike_q, spike_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ISI_W-1:0]       isi_q, isi_d;
  logic                   isi_valid_q, isi_valid_d;
  logic [ISI_W-1:0]       isi_cnt_q, isi_cnt_d;
  logic                   have_prior_q, have_prior_d;
  logic signed [13:0]     peak_trk_q, peak_trk_d;
  logic signed [13:0]     peak_v_q, peak_v_d;
  logic [RC_W-1:0]        rcnt_q, rcnt_d;
  logic                   spike_event;

  // Next-state, spike detection, ISI/count bookkeeping and peak tracking
  always_comb begin
    state_d      = state_q;
    v_reg_d      = v_in;
    // v_reg holds the reset value (0) until the first real sample lands; ARM
    // must not treat that reset value as a below-threshold reading, or a
    // neuron released from reset while depolarised would fire falsely.
    v_valid_d    = 1'b1;
    spike_d      = 1'b0;
    count_d      = count_q;
    isi_d        = isi_q;
    isi_valid_d  = isi_valid_q;
    isi_cnt_d    = isi_cnt_q;
    have_prior_d = have_prior_q;
    peak_trk_d   = peak_trk_q;
    peak_v_d     = peak_v_q;
    rcnt_d       = rcnt_q;

    spike_event = (state_q == ST_BELOW) && (v_reg_q >= THRESH_HI);

    case (state_q)
      ST_ARM: begin
        if (v_valid_q && (v_reg_q < THRESH_LO)) begin
          state_d = ST_BELOW;
        end
      end
      ST_BELOW: begin
        if (spike_event) begin
          state_d    = ST_ABOVE;
          peak_trk_d = v_reg_q;
        end
      end
      ST_ABOVE: begin
        if (v_reg_q > peak_trk_q) begin
          peak_trk_d = v_reg_q;
        end
        if (v_reg_q < THRESH_LO) begin
          // A value below THRESH_LO can never exceed the tracked peak.
          peak_v_d = peak_trk_q;
          rcnt_d   = RC_LOAD;
          state_d  = (REFRACT_CYCLES == 0) ? ST_BELOW : ST_REFRACT;
        end
      end
      default: begin // ST_REFRACT
        rcnt_d = rcnt_q - RC_W'(1);
        if (rcnt_q <= RC_W'(1)) begin
          state_d = ST_BELOW;
        end
      end
    endcase

    // Free-running interval counter restarted by every spike event
    if (spike_event) begin
      isi_cnt_d = ISI_W'(1);
    end else if (isi_cnt_q != {ISI_W{1'b1}}) begin
      isi_cnt_d = isi_cnt_q + ISI_W'(1);
    end

    if (spike_event) begin
      spike_d      = 1'b1;
      count_d      = count_q + CNT_W'(1);
      have_prior_d = 1'b1;
      if (have_prior_q && !clr) begin
        isi_d       = isi_cnt_q;
        isi_valid_d = 1'b1;
      end
    end

    // clr forgets spike history; a coincident event becomes the first spike
    if (clr) begin
      count_d      = spike_event ? CNT_W'(1) : '0;
      isi_valid_d  = 1'b0;
      have_prior_d = spike_event;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ARM;
      v_reg_q      <= '0;
      v_valid_q    <= 1'b0;
      spike_q      <= 1'b0;
      count_q      <= '0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
      isi_cnt_q    <= '0;
      have_prior_q <= 1'b0;
      peak_trk_q   <= '0;
      peak_v_q     <= '0;
      rcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      v_reg_q      <= v_reg_d;
      v_valid_q    <= v_valid_d;
      spike_q      <= spike_d;
      count_q      <= count_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
      isi_cnt_q    <= isi_cnt_d;
      have_prior_q <= have_prior_d;
      peak_trk_q   <= peak_trk_d;
      peak_v_q     <= peak_v_d;
      rcnt_q       <= rcnt_d;
    end
  end

  assign spike       = spike_q;
  assign spike_count = count_q;
  assign isi         = isi_q;
  assign isi_valid   = isi_valid_q;
  assign peak_v      = peak_v_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_hh_spike_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_hh_spike_detector
// Description : Scoreboard bench for hh_spike_detector. Three instances cover
//               default parameters, narrow ISI/count widths, and a zero-length
//               refractory window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hh_spike_detector;

  typedef struct {
    int cnt;
    int isi;
    int vld;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clr;
  logic signed [13:0] v0, v1, v2;

  logic spike0, spike1, spike2;
  logic [7:0]  cnt0;  logic [15:0] isi0; logic vld0; logic signed [13:0] peak0; logic [1:0] state0;
  logic [1:0]  cnt1;  logic [3:0]  isi1; logic vld1; logic signed [13:0] peak1; logic [1:0] state1;
  logic [7:0]  cnt2;  logic [15:0] isi2; logic vld2; logic signed [13:0] peak2; logic [1:0] state2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  hh_spike_detector dut0 (
    .clk(clk), .rst_n(rst_n), .v_in(v0), .clr(clr),
    .spike(spike0), .spike_count(cnt0), .isi(isi0), .isi_valid(vld0),
    .peak_v(peak0), .state(state0)
  );

  hh_spike_detector #(.ISI_W(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .v_in(v1), .clr(1'b0),
    .spike(spike1), .spike_count(cnt1), .isi(isi1), .isi_valid(vld1),
    .peak_v(peak1), .state(state1)
  );

  hh_spike_detector #(.REFRACT_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .v_in(v2), .clr(1'b0),
    .spike(spike2), .spike_count(cnt2), .isi(isi2), .isi_valid(vld2),
    .peak_v(peak2), .state(state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int c, input int i, input int v);
    exp_t e;
    e.cnt = c; e.isi = i; e.vld = v;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drv0(input int v); v0 = 14'(v); tick(); endtask
  task automatic drv1(input int v); v1 = 14'(v); tick(); endtask
  task automatic drv2(input int v); v2 = 14'(v); tick(); endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 1000) begin
      tick();
      guard++;
    end
    check("wait_cyc_reached", cyc, target);
  endtask

  task automatic wait_below0(input string name);
    int guard = 0;
    while (state0 != 2'd1 && guard < 100) begin
      tick();
      guard++;
    end
    check(name, int'(state0), 1);
  endtask

  // Monitor: pops the expected record whenever a DUT presents a spike pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (spike0) begin
        if (q0.size() == 0) check("dut0_unexpected_spike", 1, 0);
        else begin
          e = q0.pop_front();
          check("dut0_spike_count", int'(cnt0), e.cnt);
          check("dut0_isi", int'(isi0), e.isi);
          check("dut0_isi_valid", int'(vld0), e.vld);
        end
      end
      if (spike1) begin
        if (q1.size() == 0) check("dut1_unexpected_spike", 1, 0);
        else begin
          e = q1.pop_front();
          check("dut1_spike_count", int'(cnt1), e.cnt);
          check("dut1_isi", int'(isi1), e.isi);
          check("dut1_isi_valid", int'(vld1), e.vld);
        end
      end
      if (spike2) begin
        if (q2.size() == 0) check("dut2_unexpected_spike", 1, 0);
        else begin
          e = q2.pop_front();
          check("dut2_spike_count", int'(cnt2), e.cnt);
          check("dut2_isi", int'(isi2), e.isi);
          check("dut2_isi_valid", int'(vld2), e.vld);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int c1, c3, n;
    rst_n = 1'b0; clr = 1'b0;
    v0 = 14'sd3000; v1 = '0; v2 = '0;
    repeat (3) tick();

    // Reset values
    check("rst_state", int'(state0), 0);
    check("rst_spike", int'(spike0), 0);
    check("rst_count", int'(cnt0), 0);
    check("rst_isi", int'(isi0), 0);
    check("rst_isi_valid", int'(vld0), 0);
    check("rst_peak", int'(peak0), 0);

    // Release while depolarised: stays ARM, no spike
    rst_n = 1'b1;
    repeat (10) tick();
    check("arm_hold", int'(state0), 0);
    v0 = 14'sd1000;
    tick();
    check("arm_after_1edge", int'(state0), 0);
    tick();
    check("below_after_2edges", int'(state0), 1);
    drv0(1000); drv0(1000);

    // Single spike with peak tracking and refractory dwell
    q0.push_back(mk(1, 0, 0));
    c1 = cyc;
    drv0(2048);
    check("spike_not_yet", int'(spike0), 0);
    drv0(2500);
    check("spike_pulse", int'(spike0), 1);
    check("state_above", int'(state0), 2);
    drv0(3100);
    check("spike_one_cycle", int'(spike0), 0);
    drv0(2000); drv0(1535); drv0(1000);
    check("state_refract", int'(state0), 3);
    check("peak_v_first", int'(peak0), 3100);
    n = 1;
    while (state0 == 2'd3 && n < 100) begin
      tick();
      if (state0 == 2'd3) n++;
    end
    check("refract_dwell", n, 16);
    check("after_refract_below", int'(state0), 1);
    check("count_after_one", int'(cnt0), 1);
    check("isi_valid_after_one", int'(vld0), 0);

    // Second crossing 100 cycles later, then hysteresis oscillation
    wait_cyc(c1 + 100);
    q0.push_back(mk(2, 100, 1));
    drv0(2500);
    for (int i = 0; i < 20; i++) drv0((i % 2 == 0) ? 1600 : 2100);
    check("hysteresis_above", int'(state0), 2);
    drv0(1000);
    drv0(3000);
    check("refract_entered", int'(state0), 3);
    drv0(3000); drv0(3000); drv0(1000);
    check("refract_ignores_crossing", int'(state0), 3);
    wait_below0("refract_exit2");
    check("isi_hundred", int'(isi0), 100);
    check("count_two", int'(cnt0), 2);
    check("isi_valid_two", int'(vld0), 1);

    // clr coinciding with a spike event
    drv0(1000); drv0(1000);
    q0.push_back(mk(1, 100, 0));
    c3 = cyc;
    drv0(2500);
    clr = 1'b1;
    drv0(1000);
    clr = 1'b0;
    check("clr_event_count", int'(cnt0), 1);
    check("clr_event_isi_valid", int'(vld0), 0);
    check("clr_event_isi_hold", int'(isi0), 100);
    drv0(1000);
    check("peak_v_second", int'(peak0), 2500);

    // Next spike counts the clr spike as its predecessor
    wait_cyc(c3 + 50);
    q0.push_back(mk(2, 50, 1));
    drv0(2500);
    drv0(1000);
    check("post_clr_isi", int'(isi0), 50);

    // Reset asserted during the refractory window
    drv0(1000); drv0(1000); drv0(1000);
    check("pre_reset_refract", int'(state0), 3);
    rst_n = 1'b0;
    tick();
    check("midrefract_rst_state", int'(state0), 0);
    check("midrefract_rst_count", int'(cnt0), 0);
    check("midrefract_rst_isi", int'(isi0), 0);
    check("midrefract_rst_valid", int'(vld0), 0);
    check("midrefract_rst_peak", int'(peak0), 0);
    check("midrefract_rst_spike", int'(spike0), 0);
    rst_n = 1'b1;
    drv0(1000);

    // Narrow widths: ISI saturates at 15, count wraps modulo 4
    drv1(1000); drv1(1000); drv1(1000);
    for (int k = 0; k < 5; k++) begin
      q1.push_back(mk((k + 1) % 4, (k == 0) ? 0 : 15, (k == 0) ? 0 : 1));
      drv1(2500);
      repeat (39) drv1(1000);
    end
    check("wrap_count", int'(cnt1), 1);
    check("sat_isi", int'(isi1), 15);

    // Zero-length refractory window: ABOVE returns straight to BELOW
    drv2(1000); drv2(1000); drv2(1000);
    q2.push_back(mk(1, 0, 0));
    drv2(2500);
    drv2(1000);
    check("norefract_above", int'(state2), 2);
    drv2(1000);
    check("norefract_below", int'(state2), 1);
    q2.push_back(mk(2, 3, 1));
    drv2(2500);
    drv2(1000);
    drv2(1000); drv2(1000);
    check("norefract_isi", int'(isi2), 3);

    repeat (3) tick();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
